// File: rtl/avalon_pio_debounced.sv
// Avalon-MM PIO slave: debounced inputs with edge capture and maskable interrupt,
// plus an output register with atomic set/clear.
module avalon_pio_debounced #(
  parameter int unsigned          IN_WIDTH        = 2,
  parameter int unsigned          OUT_WIDTH       = 8,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [IN_WIDTH-1:0] sync1_q, sync2_q, stable, stable_prev_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_prev_q <= '0;
    end else begin
      sync1_q       <= pio_in;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign stable = sync2_q;
  end else begin : g_debounce
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] s_q, s_d;
    logic [CntW-1:0]     cnt_q [IN_WIDTH];
    logic [CntW-1:0]     cnt_d [IN_WIDTH];

    // Counter only advances while the synchronised level differs from s; any
    // return to s restarts the hold, and the count never passes CntLast.
    always_comb begin
      s_d = s_q;
      for (int i = 0; i < int'(IN_WIDTH); i++) begin
        cnt_d[i] = '0;
        if (sync2_q[i] != s_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            s_d[i] = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        s_q <= '0;
        for (int i = 0; i < int'(IN_WIDTH); i++) cnt_q[i] <= '0;
      end else begin
        s_q <= s_d;
        for (int i = 0; i < int'(IN_WIDTH); i++) cnt_q[i] <= cnt_d[i];
      end
    end

    assign stable = s_q;
  end

  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
  logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
  logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
  logic                 irq_q, irq_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [IN_WIDTH-1:0]  wd_in;
  logic [OUT_WIDTH-1:0] wd_out;
  logic [IN_WIDTH-1:0]  new_edges;
  logic                 unused_wd;

  assign wd_in     = avs_writedata[IN_WIDTH-1:0];
  assign wd_out    = avs_writedata[OUT_WIDTH-1:0];
  assign unused_wd = ^avs_writedata;

  assign new_edges = (stable & ~stable_prev_q & rise_en_q) |
                     (~stable & stable_prev_q & fall_en_q);

  always_comb begin
    out_d      = out_q;
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    edge_cap_d = edge_cap_q;
    if (avs_write) begin
      case (avs_address)
        3'd1:    out_d      = wd_out;
        3'd2:    out_d      = out_q | wd_out;
        3'd3:    out_d      = out_q & ~wd_out;
        3'd4:    irq_mask_d = wd_in;
        3'd5:    edge_cap_d = edge_cap_q & ~wd_in;
        3'd6:    rise_en_d  = wd_in;
        3'd7:    fall_en_d  = wd_in;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a colliding capture survives.
    edge_cap_d = edge_cap_d | new_edges;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  // Reads sample current state, so a simultaneous write returns the old value.
  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        3'd0: rdata_d = 32'(stable);
        3'd1: rdata_d = 32'(out_q);
        3'd2: rdata_d = '0;
        3'd3: rdata_d = '0;
        3'd4: rdata_d = 32'(irq_mask_q);
        3'd5: rdata_d = 32'(edge_cap_q);
        3'd6: rdata_d = 32'(rise_en_q);
        3'd7: rdata_d = 32'(fall_en_q);
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      out_q      <= OUT_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      out_q      <= out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign pio_out      = out_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_avalon_pio_debounced.sv
// Directed bench for avalon_pio_debounced: one debounced instance (16 cycles) and
// one bypass instance (0 cycles) sharing clock, reset and bus.
module tb_avalon_pio_debounced;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [1:0]  pio_in_a, pio_in_b;
  logic [7:0]  pio_out_a, pio_out_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_clk = ~clk_clk;

  avalon_pio_debounced #(
    .IN_WIDTH       (2),
    .OUT_WIDTH      (8),
    .DEBOUNCE_CYCLES(16),
    .OUT_RESET      (8'hA5)
  ) u_dut_a (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (rdata_a),
    .irq          (irq_a),
    .pio_in       (pio_in_a),
    .pio_out      (pio_out_a)
  );

  avalon_pio_debounced #(
    .IN_WIDTH       (2),
    .OUT_WIDTH      (8),
    .DEBOUNCE_CYCLES(0),
    .OUT_RESET      (8'hA5)
  ) u_dut_b (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (rdata_b),
    .irq          (irq_b),
    .pio_in       (pio_in_b),
    .pio_out      (pio_out_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    step();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, output logic [31:0] da, output logic [31:0] db);
    avs_address = addr;
    avs_read    = 1'b1;
    step();
    avs_read    = 1'b0;
    da          = rdata_a;
    db          = rdata_b;
  endtask

  logic [31:0] ra, rb;

  initial begin
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    pio_in_a      = '0;
    pio_in_b      = '0;
    step();
    reset_reset = 1'b0;

    // Reset state
    check("reset_pio_out", {24'h0, pio_out_a}, 32'hA5);
    check("reset_irq", {31'h0, irq_a}, 32'h0);
    check("reset_readdata", rdata_a, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), ra, rb);
      check($sformatf("reset_reg%0d", i), ra, (i == 1) ? 32'hA5 : 32'h0);
    end
    step();
    check("idle_readdata_zero", rdata_a, 32'h0);

    // Output register operations
    wr(3'd1, 32'h0F);
    check("out_data_write", {24'h0, pio_out_a}, 32'h0F);
    wr(3'd2, 32'h30);
    check("out_set", {24'h0, pio_out_a}, 32'h3F);
    wr(3'd3, 32'h03);
    check("out_clr", {24'h0, pio_out_a}, 32'h3C);
    rd(3'd1, ra, rb);
    check("out_data_read", ra, 32'h3C);
    rd(3'd2, ra, rb);
    check("out_set_reads_zero", ra, 32'h0);
    wr(3'd1, 32'hFFFF_FF00);
    check("out_upper_bits_ignored", {24'h0, pio_out_a}, 32'h00);

    // Read and write together: write lands, read returns the old value
    wr(3'd1, 32'h3C);
    avs_address   = 3'd1;
    avs_writedata = 32'h55;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    step();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check("rw_collision_readdata", rdata_a, 32'h3C);
    check("rw_collision_pio_out", {24'h0, pio_out_a}, 32'h55);

    // Glitch shorter than the debounce window is rejected
    pio_in_a[0] = 1'b1;
    steps(10);
    pio_in_a[0] = 1'b0;
    steps(25);
    rd(3'd0, ra, rb);
    check("glitch_rejected", ra, 32'h0);

    // Debounced rise: s flips on the 18th edge after the change, capture on the 19th,
    // irq on the 20th.
    wr(3'd6, 32'h1);
    wr(3'd4, 32'h1);
    pio_in_a[0] = 1'b1;
    steps(17);
    rd(3'd0, ra, rb);
    check("rise_not_before_18", ra, 32'h0);
    rd(3'd0, ra, rb);
    check("rise_at_18", ra, 32'h1);
    check("irq_not_yet", {31'h0, irq_a}, 32'h0);
    rd(3'd5, ra, rb);
    check("edge_cap_rise", ra, 32'h1);
    check("irq_asserted", {31'h0, irq_a}, 32'h1);

    // W1C clears the capture; irq drops one edge later
    wr(3'd5, 32'h1);
    check("irq_lags_clear", {31'h0, irq_a}, 32'h1);
    step();
    check("irq_cleared", {31'h0, irq_a}, 32'h0);

    // Falling edge with FALL_EN=0 captures nothing
    pio_in_a[0] = 1'b0;
    steps(25);
    rd(3'd5, ra, rb);
    check("fall_no_capture", ra, 32'h0);
    rd(3'd0, ra, rb);
    check("fall_in_data", ra, 32'h0);
    check("fall_irq_low", {31'h0, irq_a}, 32'h0);

    // Capture on bit 1 collides with a W1C of both bits: the set wins
    wr(3'd6, 32'h3);
    pio_in_a[1] = 1'b1;
    steps(18);
    wr(3'd5, 32'h3);
    rd(3'd5, ra, rb);
    check("collision_set_wins", ra, 32'h2);
    wr(3'd5, 32'h2);
    rd(3'd5, ra, rb);
    check("w1c_bit1", ra, 32'h0);

    // Bypass instance: IN_DATA follows pio_in after two edges
    pio_in_b[0] = 1'b1;
    step();
    rd(3'd0, ra, rb);
    check("bypass_before_2", rb, 32'h0);
    rd(3'd0, ra, rb);
    check("bypass_at_2", rb, 32'h1);

    // Reset 10 edges into a hold (count 8) forces a fresh full hold afterwards
    pio_in_a[0] = 1'b1;
    steps(10);
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    check("midreset_pio_out", {24'h0, pio_out_a}, 32'hA5);
    check("midreset_irq", {31'h0, irq_a}, 32'h0);
    steps(17);
    rd(3'd0, ra, rb);
    check("midreset_full_hold", ra, 32'h0);
    rd(3'd0, ra, rb);
    check("midreset_settled", ra, 32'h3);
    rd(3'd5, ra, rb);
    check("midreset_no_capture", ra, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_pio_debounced.md
Name: avalon_pio_debounced

Overview:
- Parametrised successor to the fixed 2-bit button / 8-bit LED PIO pair on the HPS lightweight bus.
- One Avalon-MM slave provides the following:
  - a debounced input port with per-bit rising/falling edge capture and a maskable interrupt;
  - an output port with atomic set/clear registers.
- Used for front-panel buttons, endstops and indicator LEDs of the printer controller.

Parameters:
- IN_WIDTH, 2, number of input bits (1..32).
- OUT_WIDTH, 8, number of output bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive clk_clk cycles an input must hold a new level before acceptance. 0 bypasses the debouncer.
- OUT_RESET, 0, reset value of the output register, OUT_WIDTH bits.

Ports:
- clk_clk  input  1  sole clock.
- reset_reset  input  1  synchronous, active-high reset.
- avs_address  input  3  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, fixed latency 1.
- irq  output  1  level interrupt to HPS.
- pio_in  input  IN_WIDTH  asynchronous external inputs.
- pio_out  output  OUT_WIDTH  registered outputs.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All state updates on the rising edge of clk_clk.
  - A reset mid-operation aborts any count and clears all state on the same edge.
- Reset values:
  - avs_readdata = 0, irq = 0, pio_out = OUT_RESET.
  - Synchronisers = 0, debounced state = 0, counters = 0.
  - Edge capture = 0, masks = 0, edge enables = 0.
- Input path, per bit:
  - 2-flop synchroniser, then debouncer.
  - The debouncer holds a stable value s and a counter c.
  - If sync != s: c increments. When c reaches DEBOUNCE_CYCLES-1 on a cycle where sync still != s, s takes sync and c clears.
  - If sync == s: c clears. Any glitch restarts the count.
  - Latency from pio_in change to s change is 2 + DEBOUNCE_CYCLES cycles.
  - With DEBOUNCE_CYCLES = 0, s = sync directly, so latency is 2.
  - Counter width = clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Edge detect:
  - A rising edge (s 0->1) with RISE_EN set, or a falling edge (s 1->0) with FALL_EN set, sets EDGE_CAP[bit] on the cycle after the s change.
  - If a W1C write and a new edge on the same bit land in the same cycle, the set wins.
- Interrupt:
  - irq is registered: irq = |(EDGE_CAP & IRQ_MASK), updated every cycle.
  - irq therefore follows a capture or a mask change by 1 cycle.
- Register map. Bits at or above IN_WIDTH / OUT_WIDTH read 0 and ignore writes.
  - 0 IN_DATA: RO, debounced s.
  - 1 OUT_DATA: RW, write replaces pio_out.
  - 2 OUT_SET: WO, pio_out |= wd. Reads 0.
  - 3 OUT_CLR: WO, pio_out &= ~wd. Reads 0.
  - 4 IRQ_MASK: RW.
  - 5 EDGE_CAP: read returns captured bits; write-1-to-clear.
  - 6 RISE_EN: RW.
  - 7 FALL_EN: RW.
- Bus rules:
  - Writes take effect on the edge where avs_write is sampled. pio_out changes on that edge.
  - avs_readdata is registered. It is valid the cycle after avs_read and is 0 in any cycle not following a read.
  - Reads have no side effects.
  - Simultaneous avs_read and avs_write: the write executes, and the read returns the pre-write value.
- No wait states; the slave never stalls.

Test Plan:
- Reset: assert reset_reset 1 cycle with OUT_RESET=8'hA5 -> pio_out=8'hA5, irq=0, avs_readdata=0, all registers read 0 except OUT_DATA=0xA5.
- Output ops:
  - write OUT_DATA=0x0F, then OUT_SET=0x30, then OUT_CLR=0x03 -> pio_out 0x0F, 0x3F, 0x3C on the respective write edges;
  - OUT_DATA then reads 0x3C;
  - OUT_SET reads 0.
- Debounce, DEBOUNCE_CYCLES=16:
  - pio_in[0] high for 10 cycles, then low -> IN_DATA stays 0;
  - pio_in[0] held high -> IN_DATA[0]=1 exactly 18 cycles after the change.
- Edge/IRQ:
  - RISE_EN=0x1, IRQ_MASK=0x1, debounced rise on bit 0 -> EDGE_CAP=0x1 and irq=1 on the following cycles;
  - a falling edge with FALL_EN=0 -> no capture;
  - write EDGE_CAP=0x1 -> irq=0 one cycle later.
- Collision: W1C to EDGE_CAP in the same cycle as a new rise on bit 1 (RISE_EN=0x3) -> EDGE_CAP[1] remains 1.
- Bypass and reset mid-count:
  - DEBOUNCE_CYCLES=0: input change -> IN_DATA updates after 2 cycles.
  - With DEBOUNCE_CYCLES=16: reset at count 8 -> counter clears, and a new full 16-cycle hold is needed after reset.
